// File: rtl/game_result_latch.sv
// TicTacToe result latch: latches one winner (lowest index) or a draw, holds it for
// a minimum display time before a new game, and keeps saturating per-player scores.
module game_result_latch #(
  parameter int NUM_PLAYERS = 2,
  parameter int SCORE_W = 4,
  parameter int HOLD_CYCLES = 8,
  localparam int WID_W = (NUM_PLAYERS > 2) ? $clog2(NUM_PLAYERS) : 1
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [NUM_PLAYERS-1:0]       player_win,
  input  logic                         board_full,
  input  logic                         new_game,
  output logic [NUM_PLAYERS-1:0]       player_win_indicate,
  output logic                         draw_indicate,
  output logic                         game_over,
  output logic [WID_W-1:0]             winner_id,
  output logic                         clear_ok,
  output logic [NUM_PLAYERS*SCORE_W-1:0] score
);

  typedef enum logic [1:0] {PLAY, WON, DRAW} state_t;

  localparam logic [SCORE_W-1:0] SCORE_MAX = '1;

  state_t                  state_reg, state_next;
  logic [7:0]              hold_reg, hold_next;
  logic                    clear_ok_reg, clear_ok_next;
  logic [NUM_PLAYERS-1:0]  ind_reg, ind_next;
  logic                    draw_reg, draw_next;
  logic [WID_W-1:0]        wid_reg, wid_next;
  logic [SCORE_W-1:0]      score_reg  [NUM_PLAYERS];
  logic [SCORE_W-1:0]      score_next [NUM_PLAYERS];

  logic                    win_any;
  logic [WID_W-1:0]        win_idx;

  // Lowest set index wins; scanning downward lets the lowest index overwrite last.
  always_comb begin
    win_any = |player_win;
    win_idx = '0;
    for (int i = NUM_PLAYERS - 1; i >= 0; i--) begin
      if (player_win[i]) win_idx = WID_W'(i);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) state_reg <= PLAY;
    else       state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    case (state_reg)
      PLAY: begin
        if (win_any)         state_next = WON;
        else if (board_full) state_next = DRAW;
      end
      WON, DRAW: begin
        if (new_game && clear_ok_reg) state_next = PLAY;
      end
      default: state_next = PLAY;
    endcase
  end

  // Next values for every registered output; results only form while in PLAY.
  always_comb begin
    hold_next = hold_reg;
    ind_next  = ind_reg;
    draw_next = draw_reg;
    wid_next  = wid_reg;
    for (int i = 0; i < NUM_PLAYERS; i++) score_next[i] = score_reg[i];

    if (state_next == PLAY) begin
      hold_next = '0;
      ind_next  = '0;
      draw_next = 1'b0;
      wid_next  = '0;
    end else if (state_reg == PLAY) begin
      hold_next = 8'(HOLD_CYCLES);
      if (state_next == WON) begin
        ind_next = NUM_PLAYERS'(1) << win_idx;
        wid_next = win_idx;
        if (score_reg[win_idx] != SCORE_MAX)
          score_next[win_idx] = score_reg[win_idx] + 1'b1;
      end else begin
        draw_next = 1'b1;
      end
    end else if (hold_reg != 8'd0) begin
      hold_next = hold_reg - 8'd1;
    end

    clear_ok_next = (state_next != PLAY) && (hold_next == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      hold_reg     <= '0;
      clear_ok_reg <= 1'b0;
      ind_reg      <= '0;
      draw_reg     <= 1'b0;
      wid_reg      <= '0;
      for (int i = 0; i < NUM_PLAYERS; i++) score_reg[i] <= '0;
    end else begin
      hold_reg     <= hold_next;
      clear_ok_reg <= clear_ok_next;
      ind_reg      <= ind_next;
      draw_reg     <= draw_next;
      wid_reg      <= wid_next;
      for (int i = 0; i < NUM_PLAYERS; i++) score_reg[i] <= score_next[i];
    end
  end

  generate
    for (genvar gi = 0; gi < NUM_PLAYERS; gi++) begin : g_score
      assign score[gi*SCORE_W +: SCORE_W] = score_reg[gi];
    end
  endgenerate

  assign player_win_indicate = ind_reg;
  assign draw_indicate       = draw_reg;
  assign game_over           = (state_reg != PLAY);
  assign winner_id           = wid_reg;
  assign clear_ok            = clear_ok_reg;

endmodule

// File: tb/tb_game_result_latch.sv
// Directed bench for game_result_latch: 4 players, 2-bit scores, hold of 8 cycles.
module tb_game_result_latch;
  localparam int NP = 4;
  localparam int SW = 2;
  localparam int HC = 8;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     player_win;
  logic              board_full;
  logic              new_game;
  logic [NP-1:0]     player_win_indicate;
  logic              draw_indicate;
  logic              game_over;
  logic [1:0]        winner_id;
  logic              clear_ok;
  logic [NP*SW-1:0]  score;

  int tests = 0;
  int fails = 0;
  int exp_sc [NP] = '{0, 0, 0, 0};

  game_result_latch #(.NUM_PLAYERS(NP), .SCORE_W(SW), .HOLD_CYCLES(HC)) dut (
    .clk(clk), .reset(reset), .player_win(player_win), .board_full(board_full),
    .new_game(new_game), .player_win_indicate(player_win_indicate),
    .draw_indicate(draw_indicate), .game_over(game_over), .winner_id(winner_id),
    .clear_ok(clear_ok), .score(score)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end else begin
      $display("ok   %s: %0h", tag, got);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] packed_score();
    logic [31:0] p = '0;
    for (int i = 0; i < NP; i++) p |= 32'(exp_sc[i]) << (i * SW);
    return p;
  endfunction

  // Wait (bounded) for the hold to expire, then accept a new game.
  task automatic finish_game(input string tag);
    int n = 0;
    while (!clear_ok && n < 20) begin
      step();
      n++;
    end
    check({tag, "_clear_ok_seen"}, 32'(clear_ok), 32'd1);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check({tag, "_cleared"}, 32'(game_over), 32'd0);
  endtask

  initial begin
    reset = 1'b1; player_win = '0; board_full = 1'b0; new_game = 1'b0;
    step(); step();
    check("rst_ind", 32'(player_win_indicate), 32'd0);
    check("rst_draw", 32'(draw_indicate), 32'd0);
    check("rst_go", 32'(game_over), 32'd0);
    check("rst_wid", 32'(winner_id), 32'd0);
    check("rst_clr", 32'(clear_ok), 32'd0);
    check("rst_score", 32'(score), 32'd0);

    // Single win by player 1, with hold timing
    reset = 1'b0;
    player_win = 4'b0010;
    step();                                   // entry edge N
    player_win = '0;
    exp_sc[1] = 1;
    check("win1_ind", 32'(player_win_indicate), 32'h2);
    check("win1_wid", 32'(winner_id), 32'd1);
    check("win1_go", 32'(game_over), 32'd1);
    check("win1_score", 32'(score), packed_score());
    step();                                   // N+1
    check("win1_sticky", 32'(player_win_indicate), 32'h2);
    new_game = 1'b1;
    step();                                   // N+2: early new_game dropped
    new_game = 1'b0;
    check("early_ng_go", 32'(game_over), 32'd1);
    check("early_ng_ind", 32'(player_win_indicate), 32'h2);
    for (int i = 0; i < 5; i++) step();       // N+7
    check("hold_n7", 32'(clear_ok), 32'd0);
    step();                                   // N+8
    check("hold_n8", 32'(clear_ok), 32'd1);
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("ng_ind", 32'(player_win_indicate), 32'd0);
    check("ng_go", 32'(game_over), 32'd0);
    check("ng_wid", 32'(winner_id), 32'd0);
    check("ng_clr", 32'(clear_ok), 32'd0);
    check("ng_score", 32'(score), packed_score());

    // Simultaneous wins plus full board: lowest index, no draw
    player_win = 4'b0011; board_full = 1'b1;
    step();
    player_win = '0; board_full = 1'b0;
    exp_sc[0] = 1;
    check("sim_ind", 32'(player_win_indicate), 32'h1);
    check("sim_wid", 32'(winner_id), 32'd0);
    check("sim_draw", 32'(draw_indicate), 32'd0);
    check("sim_score", 32'(score), packed_score());
    finish_game("sim");

    // Draw; new_game at the third cycle is ignored
    board_full = 1'b1;
    step();
    board_full = 1'b0;
    check("draw_flag", 32'(draw_indicate), 32'd1);
    check("draw_go", 32'(game_over), 32'd1);
    check("draw_ind", 32'(player_win_indicate), 32'd0);
    step(); step();
    new_game = 1'b1;
    step();
    new_game = 1'b0;
    check("draw_early_ng", 32'(draw_indicate), 32'd1);
    finish_game("draw");
    check("draw_cleared", 32'(draw_indicate), 32'd0);
    check("draw_score", 32'(score), packed_score());

    // Saturation of player 0 (2-bit counter): 2, 3, 3, 3
    for (int g = 0; g < 4; g++) begin
      player_win = 4'b0001;
      step();
      player_win = '0;
      exp_sc[0] = (exp_sc[0] < 3) ? exp_sc[0] + 1 : 3;
      check($sformatf("sat_g%0d", g), 32'(score), packed_score());
      finish_game($sformatf("sat_g%0d", g));
    end

    // Multi-player: lowest of players 2 and 3
    player_win = 4'b1100;
    step();
    player_win = '0;
    exp_sc[2] = 1;
    check("mp_ind", 32'(player_win_indicate), 32'h4);
    check("mp_wid", 32'(winner_id), 32'd2);
    check("mp_score", 32'(score), packed_score());

    // Back-to-back: a win present at the re-entry edge is not evaluated
    for (int n = 0; n < 20 && !clear_ok; n++) step();
    check("b2b_clr", 32'(clear_ok), 32'd1);
    new_game = 1'b1; player_win = 4'b1000;
    step();                                   // edge M
    new_game = 1'b0;
    check("b2b_m_go", 32'(game_over), 32'd0);
    check("b2b_m_ind", 32'(player_win_indicate), 32'd0);
    step();                                   // edge M+1
    player_win = '0;
    exp_sc[3] = 1;
    check("b2b_ind", 32'(player_win_indicate), 32'h8);
    check("b2b_wid", 32'(winner_id), 32'd3);
    check("b2b_score", 32'(score), packed_score());

    // Reset mid-hold clears everything, then a win latches normally
    step(); step();
    reset = 1'b1; player_win = 4'b0001;
    step();
    reset = 1'b0; player_win = '0;
    exp_sc = '{0, 0, 0, 0};
    check("mrst_ind", 32'(player_win_indicate), 32'd0);
    check("mrst_go", 32'(game_over), 32'd0);
    check("mrst_clr", 32'(clear_ok), 32'd0);
    check("mrst_score", 32'(score), 32'd0);
    player_win = 4'b0010;
    step();
    player_win = '0;
    exp_sc[1] = 1;
    check("mrst_win_ind", 32'(player_win_indicate), 32'h2);
    check("mrst_win_score", 32'(score), packed_score());

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end
endmodule
